// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the pushbutton conditioner: button indices,
// repeat FSM states and the command priority order.
package button_conditioner_pkg;

  localparam int N_BTN     = 5;
  localparam int BTN_SET   = 0;
  localparam int BTN_UP    = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 3;
  localparam int BTN_RIGHT = 4;

  // Number of buttons that auto-repeat (up and down, contiguous indices)
  localparam int N_RPT     = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // Highest priority first
  localparam int PRIO_ORDER [N_BTN] = '{BTN_SET, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT};

  // One-hot of the highest-priority request bit, or zero if none is set.
  // Walks from lowest to highest priority so the winner overwrites.
  function automatic logic [N_BTN-1:0] pick_highest(input logic [N_BTN-1:0] req);
    logic [N_BTN-1:0] grant;
    grant = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (req[PRIO_ORDER[i]]) begin
        grant                = '0;
        grant[PRIO_ORDER[i]] = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button front end: 2-flop synchronizer, debounce counter and
// stable level, with combinational press/release strobes that are valid
// in the cycle before the stable level changes.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_raw,
  output logic o_press,
  output logic o_release
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip;

  // Counter runs only while the synchronized level disagrees with stable
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    flip     = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      flip     = 1'b1;
      stable_d = ~stable_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign o_press   = flip & ~stable_q;
  assign o_release = flip &  stable_q;

  // Synchronizer chain, stable level and debounce counter
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= i_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Turns five raw pushbuttons into one-hot, single-cycle command pulses:
// per-button debounce, auto-repeat on up/down, pending bits with merge,
// and a fixed-priority arbiter feeding registered outputs.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 4,
  parameter int REPEAT_DELAY_CYCLES = 20,
  parameter int REPEAT_RATE_CYCLES  = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [N_BTN-1:0] i_btn_raw,
  output logic             o_set,
  output logic             o_up,
  output logic             o_down,
  output logic             o_left,
  output logic             o_right
);

  localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE_CYCLES - 1);

  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] rel;
  logic             unused_rel;

  for (genvar g = 0; g < N_BTN; g++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .i_clk    (i_clk),
      .i_rstn   (i_rstn),
      .i_raw    (i_btn_raw[g]),
      .o_press  (press[g]),
      .o_release(rel[g])
    );
  end

  // Release only matters to the repeating buttons
  assign unused_rel = ^{rel[BTN_SET], rel[BTN_LEFT], rel[BTN_RIGHT]};

  rpt_state_e       st_q   [N_RPT];
  rpt_state_e       st_d   [N_RPT];
  logic [RPT_W-1:0] rcnt_q [N_RPT];
  logic [RPT_W-1:0] rcnt_d [N_RPT];
  logic [N_RPT-1:0] rpt_ev;

  // Repeat FSM next state: delay before the first repeat, then fixed rate;
  // a release wins over a coincident repeat event
  always_comb begin
    for (int k = 0; k < N_RPT; k++) begin
      st_d[k]   = st_q[k];
      rcnt_d[k] = rcnt_q[k];
      rpt_ev[k] = 1'b0;
      case (st_q[k])
        IDLE: begin
          if (press[BTN_UP + k]) begin
            st_d[k]   = HOLD;
            rcnt_d[k] = '0;
          end
        end
        HOLD: begin
          if (rcnt_q[k] == DELAY_LAST) begin
            rpt_ev[k] = 1'b1;
            st_d[k]   = REPEAT;
            rcnt_d[k] = '0;
          end else begin
            rcnt_d[k] = rcnt_q[k] + 1'b1;
          end
        end
        REPEAT: begin
          if (rcnt_q[k] == RATE_LAST) begin
            rpt_ev[k] = 1'b1;
            rcnt_d[k] = '0;
          end else begin
            rcnt_d[k] = rcnt_q[k] + 1'b1;
          end
        end
        default: begin
          st_d[k]   = IDLE;
          rcnt_d[k] = '0;
        end
      endcase
      if (rel[BTN_UP + k]) begin
        st_d[k]   = IDLE;
        rcnt_d[k] = '0;
        rpt_ev[k] = 1'b0;
      end
    end
  end

  // Repeat FSM state and counters
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int k = 0; k < N_RPT; k++) begin
        st_q[k]   <= IDLE;
        rcnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_RPT; k++) begin
        st_q[k]   <= st_d[k];
        rcnt_q[k] <= rcnt_d[k];
      end
    end
  end

  logic [N_BTN-1:0] ev;
  logic [N_BTN-1:0] grant;
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [N_BTN-1:0] out_q;

  // Collect events, arbitrate, and merge events into already-pending bits
  always_comb begin
    ev           = press;
    ev[BTN_UP]   = press[BTN_UP]   | rpt_ev[0];
    ev[BTN_DOWN] = press[BTN_DOWN] | rpt_ev[1];
    grant        = pick_highest(pend_q);
    pend_d       = (pend_q & ~grant) | (ev & ~pend_q);
  end

  // Pending bits and registered one-hot command outputs
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pend_q <= '0;
      out_q  <= '0;
    end else begin
      pend_q <= pend_d;
      out_q  <= grant;
    end
  end

  assign o_set   = out_q[BTN_SET];
  assign o_up    = out_q[BTN_UP];
  assign o_down  = out_q[BTN_DOWN];
  assign o_left  = out_q[BTN_LEFT];
  assign o_right = out_q[BTN_RIGHT];

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with default parameters.
// Each scenario pushes the expected output vector for the cycles where a
// pulse must appear; every other cycle the outputs must be all-zero.
module tb_button_conditioner;

  logic       clk;
  logic       rstn;
  logic [4:0] raw;
  logic       o_set, o_up, o_down, o_left, o_right;

  button_conditioner dut (
    .i_clk    (clk),
    .i_rstn   (rstn),
    .i_btn_raw(raw),
    .o_set    (o_set),
    .o_up     (o_up),
    .o_down   (o_down),
    .o_left   (o_left),
    .o_right  (o_right)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] vec;
  } exp_t;

  exp_t sb [$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  logic [4:0] mon_want;

  localparam logic [4:0] V_SET   = 5'b00001;
  localparam logic [4:0] V_UP    = 5'b00010;
  localparam logic [4:0] V_DOWN  = 5'b00100;
  localparam logic [4:0] V_LEFT  = 5'b01000;
  localparam logic [4:0] V_RIGHT = 5'b10000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", tag, got, want);
    end
  endtask

  task automatic expect_at(input int c, input logic [4:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    sb.push_back(e);
  endtask

  // Returns the index of edge E; raw changes just after it
  task automatic start_edge(output int e);
    @(posedge clk);
    #1;
    e = cyc;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare the whole output vector every cycle against the scoreboard
  always @(negedge clk) begin
    mon_want = '0;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_want = sb[0].vec;
      void'(sb.pop_front());
    end
    chk($sformatf("out@%0d", cyc), {o_right, o_left, o_down, o_up, o_set}, mon_want);
  end

  initial begin
    int         e;
    logic [4:0] bounce;
    rstn = 1'b0;
    raw  = '0;
    step(3);
    chk("reset_outputs", {o_right, o_left, o_down, o_up, o_set}, 5'b00000);
    rstn = 1'b1;
    step(10);

    // Bounce on up: 1,0,1,1,0 -> nothing
    bounce = 5'b01101;
    start_edge(e);
    for (int i = 0; i < 5; i++) begin
      raw[1] = bounce[i];
      step(1);
    end
    raw = '0;
    step(30);

    // Clean tap on left: single pulse, nothing on release
    start_edge(e);
    expect_at(e + 7, V_LEFT);
    raw[3] = 1'b1;
    step(10);
    raw = '0;
    step(30);

    // Hold up 60 cycles: press pulse then repeats; repeat coinciding
    // with release is suppressed
    start_edge(e);
    expect_at(e + 7,  V_UP);
    expect_at(e + 27, V_UP);
    expect_at(e + 35, V_UP);
    expect_at(e + 43, V_UP);
    expect_at(e + 51, V_UP);
    expect_at(e + 59, V_UP);
    raw[1] = 1'b1;
    step(60);
    raw = '0;
    step(30);

    // Simultaneous set and up
    start_edge(e);
    expect_at(e + 7, V_SET);
    expect_at(e + 8, V_UP);
    raw = 5'b00011;
    step(10);
    raw = '0;
    step(30);

    // Simultaneous down, left, right: priority order
    start_edge(e);
    expect_at(e + 7, V_DOWN);
    expect_at(e + 8, V_LEFT);
    expect_at(e + 9, V_RIGHT);
    raw = 5'b11100;
    step(10);
    raw = '0;
    step(30);

    // Reset mid-hold on down, button held through reset
    start_edge(e);
    expect_at(e + 7,  V_DOWN);
    expect_at(e + 27, V_DOWN);
    expect_at(e + 40, V_DOWN);
    expect_at(e + 60, V_DOWN);
    expect_at(e + 68, V_DOWN);
    expect_at(e + 76, V_DOWN);
    expect_at(e + 84, V_DOWN);
    raw[2] = 1'b1;
    step(30);
    rstn = 1'b0;
    #1;
    chk("async_reset_clear", {o_right, o_left, o_down, o_up, o_set}, 5'b00000);
    step(3);
    rstn = 1'b1;
    step(47);
    raw = '0;
    step(30);

    // Set and up held together: one set, up press plus its repeats
    start_edge(e);
    expect_at(e + 7,  V_SET);
    expect_at(e + 8,  V_UP);
    expect_at(e + 27, V_UP);
    expect_at(e + 35, V_UP);
    expect_at(e + 43, V_UP);
    raw = 5'b00011;
    step(40);
    raw = '0;
    step(30);

    chk("sb_drained", 5'(sb.size()), 5'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
